// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: S-box table, GF(2^8) doubling,
// round-key type and the key-expansion FSM state encoding.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo the AES polynomial; drives the rcon sequence.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups, usable inside the
// single-cycle key-schedule iteration.
module aes_sub_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  import aes_pkg::*;

  assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                   SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, all round keys
// held in registers and presented as a flat bus once complete.
module aes_key_expand #(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          key_valid,
  output logic                          key_ready,
  input  logic [127:0]                  key,
  output logic [128*(NUM_ROUNDS+1)-1:0] round_keys,
  output logic                          keys_valid
);
  import aes_pkg::*;

  localparam int CW = $clog2(NUM_ROUNDS + 2);

  ks_state_t  r_state;
  ks_state_t  w_next_state;
  round_key_t r_rk [NUM_ROUNDS+1];
  logic [CW-1:0] r_count;
  logic [7:0] r_rcon;

  logic       w_accept;
  round_key_t w_prev;
  round_key_t w_next_key;
  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_temp;
  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [31:0] w_w2;
  logic [31:0] w_w3;

  assign w_accept = key_valid && key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next_state = ST_EXPAND;
      ST_EXPAND: if (r_count == CW'(NUM_ROUNDS)) w_next_state = ST_READY;
      ST_READY:  if (w_accept) w_next_state = ST_EXPAND;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    key_ready  = 1'b1;
    keys_valid = 1'b0;
    case (r_state)
      ST_EXPAND: key_ready  = 1'b0;
      ST_READY:  keys_valid = 1'b1;
      default:   ;
    endcase
  end

  // The key being extended is always the one written on the previous cycle.
  always_comb begin
    w_prev = '0;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (r_count == CW'(i + 1)) w_prev = r_rk[i];
    end
  end

  assign w_rot = {w_prev[23:0], w_prev[31:24]};

  aes_sub_word u_sub_word (
    .i_word (w_rot),
    .o_word (w_sub)
  );

  assign w_temp     = w_sub ^ {r_rcon, 24'h0};
  assign w_w0       = w_prev[127:96] ^ w_temp;
  assign w_w1       = w_prev[95:64]  ^ w_w0;
  assign w_w2       = w_prev[63:32]  ^ w_w1;
  assign w_w3       = w_prev[31:0]   ^ w_w2;
  assign w_next_key = {w_w0, w_w1, w_w2, w_w3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) r_rk[i] <= '0;
      r_count <= '0;
      r_rcon  <= 8'h01;
    end else if (w_accept) begin
      r_rk[0] <= key;
      r_count <= CW'(1);
      r_rcon  <= 8'h01;
    end else if (r_state == ST_EXPAND) begin
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
        if (r_count == CW'(i)) r_rk[i] <= w_next_key;
      end
      r_count <= r_count + CW'(1);
      r_rcon  <= xtime(r_rcon);
    end
  end

  for (genvar g = 0; g <= NUM_ROUNDS; g++) begin : g_out
    assign round_keys[128*g +: 128] = r_rk[g];
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: an independent FIPS-197 key
// expansion (S-box derived from GF(2^8) inverses) checked every cycle.
module tb_aes_key_expand;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10= 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic           clk;
  logic           rst_n;
  logic           key_valid;
  logic           key_ready;
  logic [127:0]   key;
  logic [1407:0]  round_keys;
  logic           keys_valid;

  int asserts  = 0;
  int failures = 0;

  logic [7:0]    sbox [256];
  logic [1407:0] modelFlat;
  bit            expBusy;
  bit            expHaveKey;
  int            sinceAccept;

  aes_key_expand #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key        (key),
    .round_keys (round_keys),
    .keys_valid (keys_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gfMul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-oriented FIPS-197 expansion over w[0..43]; round key r lands at slice r.
  function automatic logic [1407:0] expandModel(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gfMul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) res[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    asserts++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Protocol scoreboard: what was accepted and how many cycles ago.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expBusy     <= 1'b0;
      expHaveKey  <= 1'b0;
      sinceAccept <= 0;
    end else if (key_valid && !expBusy) begin
      modelFlat   <= expandModel(key);
      expHaveKey  <= 1'b1;
      expBusy     <= 1'b1;
      sinceAccept <= 0;
    end else if (expBusy) begin
      sinceAccept <= sinceAccept + 1;
      if (sinceAccept == 9) expBusy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("key_ready", 128'(key_ready), 128'(!expBusy));
      checkOutput("keys_valid", 128'(keys_valid), 128'(expHaveKey && !expBusy));
      for (int j = 0; j < 11; j++) begin
        if (!expHaveKey)
          checkOutput($sformatf("rk%0d idle", j), round_keys[128*j +: 128], 128'h0);
        else if (j <= sinceAccept)
          checkOutput($sformatf("rk%0d", j), round_keys[128*j +: 128], modelFlat[128*j +: 128]);
      end
    end
  end

  task automatic applyStimulus(input logic [127:0] k, output int latency);
    int waitCnt;
    waitCnt = 0;
    latency = -1;
    @(negedge clk);
    key       = k;
    key_valid = 1'b1;
    while (!key_ready && waitCnt < 30) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!key_ready) begin
      checkOutput("accept wait key_ready", 128'(key_ready), 128'h1);
      key_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    latency = 0;
    while (latency < 30) begin
      @(posedge clk);
      #1;
      latency++;
      if (keys_valid) break;
    end
    checkOutput("accept-to-valid latency", 128'(latency), 128'd10);
  endtask

  task automatic checkAllZero(input string tag);
    for (int j = 0; j < 11; j++)
      checkOutput($sformatf("%s rk%0d", tag, j), round_keys[128*j +: 128], 128'h0);
  endtask

  initial begin
    int lat;
    int pulses;
    int loaded;
    logic [127:0] keyB;

    buildSbox();
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key       = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset state");
    repeat (6) @(negedge clk);
    checkOutput("reset key_ready", 128'(key_ready), 128'h1);
    checkOutput("reset keys_valid", 128'(keys_valid), 128'h0);
    checkAllZero("reset");

    $display("[TB] FIPS-197 A.1 key");
    applyStimulus(KEY_A1, lat);
    checkOutput("A1 rk0", round_keys[0 +: 128], KEY_A1);
    checkOutput("A1 rk1", round_keys[128 +: 128], A1_RK1);
    checkOutput("A1 rk10", round_keys[1280 +: 128], A1_RK10);
    checkOutput("model A1 rk1", modelFlat[128 +: 128], A1_RK1);
    checkOutput("model A1 rk10", modelFlat[1280 +: 128], A1_RK10);

    $display("[TB] all-zero key");
    applyStimulus(128'h0, lat);
    checkOutput("zero rk1", round_keys[128 +: 128], ZERO_RK1);
    checkOutput("zero rk10", round_keys[1280 +: 128], ZERO_RK10);
    checkOutput("model zero rk1", modelFlat[128 +: 128], ZERO_RK1);
    checkOutput("model zero rk10", modelFlat[1280 +: 128], ZERO_RK10);

    $display("[TB] busy: second key held during expansion");
    keyB = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    key       = KEY_A1;
    key_valid = 1'b1;
    checkOutput("busy pre key_ready", 128'(key_ready), 128'h1);
    @(posedge clk);
    #1;
    key = keyB;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk);
      #1;
      checkOutput("busy key_ready low", 128'(key_ready), 128'h0);
      checkOutput("busy rk0 holds A", round_keys[0 +: 128], KEY_A1);
    end
    @(posedge clk);
    #1;
    checkOutput("busy A valid", 128'(keys_valid), 128'h1);
    checkOutput("busy A rk10", round_keys[1280 +: 128], A1_RK10);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    checkOutput("busy B accept drops valid", 128'(keys_valid), 128'h0);
    checkOutput("busy B rk0", round_keys[0 +: 128], keyB);
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (keys_valid) break;
    end
    checkOutput("busy B latency", 128'(lat), 128'd10);

    $display("[TB] reset during expansion");
    @(negedge clk);
    key       = KEY_A1;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset key_ready", 128'(key_ready), 128'h1);
    checkOutput("async reset keys_valid", 128'(keys_valid), 128'h0);
    checkAllZero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(KEY_A1, lat);
    checkOutput("post-reset A1 rk10", round_keys[1280 +: 128], A1_RK10);

    $display("[TB] back-to-back re-key");
    pulses = 0;
    @(negedge clk);
    key       = KEY_A1;
    key_valid = 1'b1;
    loaded    = 1;
    for (int i = 1; i <= 55; i++) begin
      @(negedge clk);
      if (keys_valid) begin
        pulses++;
        checkOutput($sformatf("b2b pulse %0d rk10", pulses), round_keys[1280 +: 128],
                    (pulses % 2 == 1) ? A1_RK10 : ZERO_RK10);
      end
      if (key_ready) begin
        key = (loaded % 2 == 1) ? 128'h0 : KEY_A1;
        loaded++;
      end
    end
    key_valid = 1'b0;
    checkOutput("b2b pulse count", 128'(pulses), 128'd5);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      key_valid = ($urandom_range(0, 3) != 0);
      key       = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    key_valid = 1'b0;
    repeat (15) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
